instr_fetch_queue: RTL

//  Front-end fetch stage directly upstream of the decoder. Issues sequential

---
 rtl/instr_fetch_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: front-end fetch stage feeding the decoder.
// Issues sequential icache fetches with at most one request outstanding. Returned
// words are buffered with their PCs in a circular queue and handed to the decoder
// over a valid/ready handshake. A flush from the commit side redirects fetch and
// empties the queue. If a request is still in flight at a flush, its stale response
// is dropped.
// Optional build macro IFQ_JAL_PREDICT_EN: on enqueue of a JAL word, fetch
// continues at the JAL target instead of PC+4.
// DEPTH must be a power of two, >= 2, so that the pointers wrap on their own.

module instr_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_instr,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [PW-1:0]  head_r, head_nxt_s;
    logic [PW-1:0]  tail_r, tail_nxt_s;
    logic [CW-1:0]  count_r, count_nxt_s;
    logic [31:0]    fetch_pc_r, fetch_pc_nxt_s;
    logic           req_en_r, req_en_nxt_s;
    logic           enq_s, deq_s, accept_s;
    logic [63:0]    mem_r [0:DEPTH-1];
`ifdef IFQ_JAL_PREDICT_EN
    logic [31:0]    jal_imm_s;
`endif

    // req_en_r mirrors "IDLE and not full" as a register.
    // The request line is therefore low in reset, and it drops in a flush cycle.
    assign icache_req_valid = req_en_r & ~(flush_in & rdy_in);
    assign icache_req_addr  = fetch_pc_r;
    assign accept_s         = icache_req_valid & icache_req_ready;

    // Head entry is read directly from storage; it is forced to zero when the queue is empty.
    assign dec_valid = (count_r != {CW{1'b0}});
    assign dec_pc    = dec_valid ? mem_r[head_r][63:32] : 32'h0000_0000;
    assign dec_instr = dec_valid ? mem_r[head_r][31:0]  : 32'h0000_0000;

    // Next-state, pointer, count and fetch-PC computation; a flush overrides everything else.
    always_comb begin
        state_nxt_s    = state_r;
        head_nxt_s     = head_r;
        tail_nxt_s     = tail_r;
        count_nxt_s    = count_r;
        fetch_pc_nxt_s = fetch_pc_r;
        enq_s          = 1'b0;
        deq_s          = 1'b0;
`ifdef IFQ_JAL_PREDICT_EN
        jal_imm_s      = {{11{icache_resp_instr[31]}}, icache_resp_instr[31],
                          icache_resp_instr[19:12], icache_resp_instr[20],
                          icache_resp_instr[30:21], 1'b0};
`endif
        if (flush_in) begin
            head_nxt_s     = {PW{1'b0}};
            tail_nxt_s     = {PW{1'b0}};
            count_nxt_s    = {CW{1'b0}};
            fetch_pc_nxt_s = flush_pc_in & 32'hFFFF_FFFC;
            // A response arriving with the flush retires the in-flight request.
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_WAIT: state_nxt_s = icache_resp_valid ? ST_IDLE : ST_DROP;
                ST_DROP: state_nxt_s = icache_resp_valid ? ST_IDLE : ST_DROP;
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            deq_s = dec_valid & dec_ready;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (icache_resp_valid) begin
                        enq_s          = 1'b1;
                        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
`ifdef IFQ_JAL_PREDICT_EN
                        if (icache_resp_instr[6:0] == 7'b1101111) begin
                            fetch_pc_nxt_s = fetch_pc_r + jal_imm_s;
                        end else begin
                            fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                        end
`endif
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (icache_resp_valid) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
            if (enq_s) begin
                tail_nxt_s = tail_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                tail_nxt_s = tail_r;
            end
            if (deq_s) begin
                head_nxt_s = head_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                head_nxt_s = head_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_nxt_s = count_r;
            endcase
        end
        req_en_nxt_s = (state_nxt_s == ST_IDLE) && (count_nxt_s < DEPTH_C);
    end

    // Control registers: async reset, frozen whenever rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            fetch_pc_r <= RESET_PC;
            req_en_r   <= 1'b0;
        end else if (rdy_in) begin
            state_r    <= state_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            count_r    <= count_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            req_en_r   <= req_en_nxt_s;
        end
    end

    // Queue storage: write {pc, instr} at the tail on enqueue; contents need no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && enq_s) begin
            mem_r[tail_r] <= {fetch_pc_r, icache_resp_instr};
        end
    end

endmodule
